// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: boot fill, load-use bubbles,
// taken-branch flushes and data-memory wait stalls, plus saturating perf counters.
//
//   state       | meaning
//   ST_BOOT     | holding PC after reset while the pipeline fills with bubbles
//   ST_RUN      | normal issue; branch flush / load-use bubble evaluated here
//   ST_MEM_WAIT | data memory access outstanding; whole front end frozen
module pipe_hazard_ctrl #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int BOOT_CYCLES        = 4,
  parameter int MEM_TIMEOUT        = 255,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr,
  input  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr,
  input  logic                          ID_Rs1_used,
  input  logic                          ID_Rs2_used,
  input  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr,
  input  logic                          EX_Mem_rd_en,
  input  logic                          EX_Branch_taken,
  input  logic                          MEM_Mem_req,
  input  logic                          DMem_ready,
  output logic                          PC_stall,
  output logic                          IF_ID_stall,
  output logic                          ID_EX_stall,
  output logic                          EX_MEM_stall,
  output logic                          IF_ID_flush,
  output logic                          ID_EX_flush,
  output logic                          MEM_WB_flush,
  output logic                          Mem_timeout,
  output logic [CNT_WIDTH-1:0]          Stall_count,
  output logic [CNT_WIDTH-1:0]          Flush_count
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        boot_cnt_q, boot_cnt_d;
  logic [WW-1:0]        wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 load_use;
  logic                 mem_wait;
  logic                 branch_flush;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = EX_Mem_rd_en && (EX_Rd_addr != '0) &&
                    ((ID_Rs1_used && (ID_Rs1_addr == EX_Rd_addr)) ||
                     (ID_Rs2_used && (ID_Rs2_addr == EX_Rd_addr)));

  assign mem_wait = ((state_q == ST_RUN) && MEM_Mem_req && !DMem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !DMem_ready);

  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    MEM_WB_flush = 1'b0;
    branch_flush = 1'b0;
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;

    case (state_q)
      ST_BOOT: begin
        PC_stall    = 1'b1;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BW'(1);
        end
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (mem_wait) begin
          PC_stall     = 1'b1;
          IF_ID_stall  = 1'b1;
          ID_EX_stall  = 1'b1;
          EX_MEM_stall = 1'b1;
          MEM_WB_flush = 1'b1;
          state_d      = ST_MEM_WAIT;
          if (state_q == ST_RUN) begin
            wait_cnt_d = WW'(1);
          end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
          end
          // Timeout only raises a flag; the stall keeps holding the pipeline
          if (wait_cnt_d == WAIT_MAX) begin
            timeout_d = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          if (EX_Branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            branch_flush = 1'b1;
          end else if (load_use) begin
            PC_stall    = 1'b1;
            IF_ID_stall = 1'b1;
            ID_EX_flush = 1'b1;
          end
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (PC_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
    if (branch_flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Mem_timeout = timeout_q;
  assign Stall_count = stall_cnt_q;
  assign Flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: boot, load-use, branch, mem wait,
// timeout, reset-in-wait and counter saturation with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int RA = 5;

  // {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, MEM_WB_flush}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_BOOT   = 7'b1000110;
  localparam logic [6:0] C_LDUSE  = 7'b1100010;
  localparam logic [6:0] C_BRANCH = 7'b0000110;
  localparam logic [6:0] C_MWAIT  = 7'b1111001;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [RA-1:0] ID_Rs1_addr, ID_Rs2_addr, EX_Rd_addr;
  logic          ID_Rs1_used, ID_Rs2_used, EX_Mem_rd_en, EX_Branch_taken;
  logic          MEM_Mem_req, DMem_ready;
  logic          PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
  logic          IF_ID_flush, ID_EX_flush, MEM_WB_flush, Mem_timeout;
  logic [3:0]    Stall_count, Flush_count;
  logic [6:0]    ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(
    .REGFILE_ADDR_WIDTH(RA),
    .BOOT_CYCLES       (4),
    .MEM_TIMEOUT       (8),
    .CNT_WIDTH         (4)
  ) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .ID_Rs1_addr    (ID_Rs1_addr),
    .ID_Rs2_addr    (ID_Rs2_addr),
    .ID_Rs1_used    (ID_Rs1_used),
    .ID_Rs2_used    (ID_Rs2_used),
    .EX_Rd_addr     (EX_Rd_addr),
    .EX_Mem_rd_en   (EX_Mem_rd_en),
    .EX_Branch_taken(EX_Branch_taken),
    .MEM_Mem_req    (MEM_Mem_req),
    .DMem_ready     (DMem_ready),
    .PC_stall       (PC_stall),
    .IF_ID_stall    (IF_ID_stall),
    .ID_EX_stall    (ID_EX_stall),
    .EX_MEM_stall   (EX_MEM_stall),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_flush    (ID_EX_flush),
    .MEM_WB_flush   (MEM_WB_flush),
    .Mem_timeout    (Mem_timeout),
    .Stall_count    (Stall_count),
    .Flush_count    (Flush_count)
  );

  assign ctrl = {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                 IF_ID_flush, ID_EX_flush, MEM_WB_flush};

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_Rs1_addr     = '0;
    ID_Rs2_addr     = '0;
    EX_Rd_addr      = '0;
    ID_Rs1_used     = 1'b0;
    ID_Rs2_used     = 1'b0;
    EX_Mem_rd_en    = 1'b0;
    EX_Branch_taken = 1'b0;
    MEM_Mem_req     = 1'b0;
    DMem_ready      = 1'b0;
  endtask

  task automatic set_load_use_rs1();
    EX_Mem_rd_en = 1'b1;
    EX_Rd_addr   = 5'd5;
    ID_Rs1_addr  = 5'd5;
    ID_Rs1_used  = 1'b1;
    ID_Rs2_addr  = 5'd7;
    ID_Rs2_used  = 1'b1;
  endtask

  initial begin
    clear_inputs();
    Reset_n = 1'b0;
    #12;
    check("rst_ctrl", ctrl, C_BOOT);
    check("rst_stall_cnt", Stall_count, 0);
    check("rst_flush_cnt", Flush_count, 0);
    check("rst_timeout", Mem_timeout, 0);
    Reset_n = 1'b1;

    // Boot: four held cycles, released on the fifth
    for (int i = 0; i < 4; i++) begin
      check($sformatf("boot_ctrl_%0d", i), ctrl, C_BOOT);
      tick();
    end
    check("boot_done_ctrl", ctrl, C_NONE);
    check("boot_stall_cnt", Stall_count, 4);

    // Load x5 in EX, ID uses rs2=x5
    EX_Mem_rd_en = 1'b1; EX_Rd_addr = 5'd5;
    ID_Rs1_addr = 5'd3; ID_Rs1_used = 1'b1;
    ID_Rs2_addr = 5'd5; ID_Rs2_used = 1'b1;
    #1 check("lu_rs2_ctrl", ctrl, C_LDUSE);
    tick();
    check("lu_rs2_stall_cnt", Stall_count, 5);
    clear_inputs();
    #1 check("lu_clear_ctrl", ctrl, C_NONE);

    // Load to x0 never stalls
    EX_Mem_rd_en = 1'b1; EX_Rd_addr = 5'd0;
    ID_Rs1_used = 1'b1; ID_Rs2_used = 1'b1;
    #1 check("lu_x0_ctrl", ctrl, C_NONE);

    // Matching address but operand not read
    EX_Rd_addr = 5'd5; ID_Rs1_addr = 5'd5;
    ID_Rs1_used = 1'b0; ID_Rs2_used = 1'b0;
    #1 check("lu_unused_ctrl", ctrl, C_NONE);

    set_load_use_rs1();
    #1 check("lu_rs1_ctrl", ctrl, C_LDUSE);
    tick();
    check("lu_rs1_stall_cnt", Stall_count, 6);

    // Load-use together with taken branch: branch wins
    set_load_use_rs1();
    EX_Branch_taken = 1'b1;
    #1 check("br_lu_ctrl", ctrl, C_BRANCH);
    tick();
    check("br_flush_cnt", Flush_count, 1);
    check("br_stall_cnt", Stall_count, 6);
    clear_inputs();

    // Three wait cycles; a taken branch during the wait is ignored
    MEM_Mem_req = 1'b1; DMem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      EX_Branch_taken = (k == 1);
      #1 check($sformatf("mw_ctrl_%0d", k), ctrl, C_MWAIT);
      tick();
    end
    EX_Branch_taken = 1'b0;
    DMem_ready = 1'b1;
    set_load_use_rs1();
    #1 check("mw_ready_lu_ctrl", ctrl, C_LDUSE);
    tick();
    check("mw_stall_cnt", Stall_count, 10);
    check("mw_flush_cnt", Flush_count, 1);
    clear_inputs();
    #1 check("mw_run_ctrl", ctrl, C_NONE);
    check("mw_no_timeout", Mem_timeout, 0);

    // Never-ready memory: flag after 8 wait cycles; also saturates Stall_count
    MEM_Mem_req = 1'b1; DMem_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1 check($sformatf("to_flag_%0d", k), Mem_timeout, (k >= 9) ? 1 : 0);
      tick();
    end
    check("to_ctrl", ctrl, C_MWAIT);
    check("sat_stall_cnt", Stall_count, 15);
    DMem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("to_sticky", Mem_timeout, 1);
    check("to_after_ctrl", ctrl, C_NONE);
    check("sat_hold_stall_cnt", Stall_count, 15);

    // Reset while stuck in wait
    MEM_Mem_req = 1'b1; DMem_ready = 1'b0;
    tick();
    tick();
    #2 Reset_n = 1'b0;
    #1;
    check("rst_mw_timeout", Mem_timeout, 0);
    check("rst_mw_stall_cnt", Stall_count, 0);
    check("rst_mw_flush_cnt", Flush_count, 0);
    check("rst_mw_ctrl", ctrl, C_BOOT);
    clear_inputs();
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("reboot_ctrl", ctrl, C_NONE);
    check("reboot_stall_cnt", Stall_count, 4);

    // Flush counter saturation
    EX_Branch_taken = 1'b1;
    #1 check("brsat_ctrl", ctrl, C_BRANCH);
    for (int i = 0; i < 17; i++) tick();
    check("sat_flush_cnt", Flush_count, 15);
    check("brsat_stall_cnt", Stall_count, 4);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
